br_puf_ctrl: RTL and testbench
==============================

Name: br_puf_ctrl

Overview:
- Evaluation controller that sits directly upstream of the 64-bit bistable-ring PUF macro and drives its challenge and ring-reset inputs.
- Accepts a 64-bit challenge over a valid/ready handshake and applies it to the ring.
- Evaluates the ring NUM_EVALS times. Each evaluation is a ring-reset pulse, a settle window, then a sample of the ring output.
- Majority-votes the samples and returns one response bit plus the raw ones-count over a valid/ready handshake.

Parameters:
- RESET_CYCLES, 4, cycles BR_RESET is held high per evaluation (>=1).
- SETTLE_CYCLES, 16, cycles waited after BR_RESET falls before sampling (>=3, covers the 2-flop synchroniser).
- NUM_EVALS, 5, evaluations per challenge (odd, 1..255).
- CW, $clog2(NUM_EVALS+1), width of the ones counter and RESP_ONES.

Ports:
- CLK  input  1  block clock.
- RESET_N  input  1  asynchronous active-low reset.
- CHAL_VALID  input  1  challenge offered.
- CHAL_READY  output  1  controller idle; challenge accepted on CHAL_VALID&&CHAL_READY.
- CHAL  input  64  challenge bits.
- BR_C  output  64  challenge to the PUF C input.
- BR_RESET  output  1  ring reset to the PUF RESET input, active-high.
- BR_OUT  input  1  PUF OUT; asynchronous to CLK.
- RESP_VALID  output  1  response available.
- RESP_READY  input  1  response consumed on RESP_VALID&&RESP_READY.
- RESP  output  1  majority-voted response bit.
- RESP_ONES  output  CW  number of evaluations that sampled 1.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; BR_C=0, BR_RESET=0, RESP_VALID=0, RESP=0, RESP_ONES=0.
  - Counters=0; synchroniser flops=0; CHAL_READY=1, BUSY=0.
- Synchroniser: BR_OUT passes through two CLK flops (sync_q) before any use. BR_OUT is never used raw.
- States: IDLE, RST, SETTLE, SAMPLE, DONE. CHAL_READY=(state==IDLE).
- IDLE:
  - On handshake at edge k: BR_C<=CHAL, ones<=0, eval<=0, state<=RST.
  - BR_C holds this value until the next accepted challenge. It never changes outside an IDLE handshake.
- RST:
  - BR_RESET=1 (registered output) for exactly RESET_CYCLES cycles.
  - The first RST cycle is k+1. Then state<=SETTLE.
- SETTLE: BR_RESET=0 for exactly SETTLE_CYCLES cycles, then state<=SAMPLE.
- SAMPLE (1 cycle):
  - ones<=ones+sync_q; eval<=eval+1.
  - If eval+1==NUM_EVALS, state<=DONE. Otherwise state<=RST.
- Per-evaluation period is RESET_CYCLES+SETTLE_CYCLES+1. First RESP_VALID cycle is k+1+NUM_EVALS*(RESET_CYCLES+SETTLE_CYCLES+1); with defaults that is k+106.
- DONE:
  - RESP_VALID=1; RESP=(ones > NUM_EVALS/2); RESP_ONES=ones.
  - RESP and RESP_ONES are stable while RESP_VALID is high.
  - On RESP_READY: state<=IDLE, RESP_VALID<=0. RESP and RESP_ONES keep their last value until the next DONE.
- CHAL_VALID is ignored while BUSY. A challenge cannot be accepted in the same cycle the response is consumed; IDLE is first reachable one cycle later.
- RESP_READY outside DONE has no effect.
- The ones counter cannot overflow because CW covers NUM_EVALS.
- Reset mid-operation:
  - BR_RESET and RESP_VALID drop asynchronously, and any partial count is discarded.
  - BR_C returns to 0.
  - After release the block restarts in IDLE.

Test Plan:
- PUF model OUT tied 1, defaults, CHAL=64'hDEADBEEF_01234567 accepted at edge k:
  - BR_C==64'hDEADBEEF_01234567 from k+1.
  - BR_RESET high on cycles k+1..k+4, k+22..k+25, and so on.
  - RESP_VALID rises at k+106 with RESP=1, RESP_ONES=5.
- PUF behavioural model (OUT toggles on each BR_RESET rising edge, starts 0):
  - Samples are 1,0,1,0,1.
  - RESP=1, RESP_ONES=3.
- Model OUT tied 0:
  - RESP=0, RESP_ONES=0.
  - Then CHAL_VALID held high with a new challenge during BUSY: not accepted, and BR_C is unchanged until IDLE.
- Backpressure: RESP_READY low 20 cycles after RESP_VALID.
  - RESP_VALID, RESP and RESP_ONES stay stable, and CHAL_READY stays 0.
  - RESP_READY=1 for one cycle: next cycle RESP_VALID=0, CHAL_READY=1.
- Assert RESET_N low during the 3rd SETTLE:
  - BR_RESET=0, BR_C=0, RESP_VALID=0 without waiting for a CLK edge.
  - After release a fresh challenge completes normally at k+106.
- Glitch BR_OUT high for 1 ns inside SETTLE but low at sample time:
  - The sample contributes 0, confirming only the synchronised sample in SAMPLE is used.

Source files
------------

// File: rtl/br_puf_ctrl.sv
// br_puf_ctrl: evaluation controller for a 64-bit bistable-ring PUF.
// Applies an accepted challenge and pulses the ring reset NUM_EVALS times.
// It samples the synchronised ring output after each settle window.
// It returns the majority vote together with the raw ones-count.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a challenge, CHAL_READY high
// RST    | BR_RESET high, timer counts down RESET_CYCLES
// SETTLE | BR_RESET low, timer counts down SETTLE_CYCLES
// SAMPLE | one cycle: accumulate sync_q into ones, advance eval count
// DONE   | response presented until RESP_READY
module br_puf_ctrl #(
  parameter int RESET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int NUM_EVALS     = 5,
  parameter int CW            = $clog2(NUM_EVALS + 1)
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          CHAL_VALID,
  output logic          CHAL_READY,
  input  logic [63:0]   CHAL,
  output logic [63:0]   BR_C,
  output logic          BR_RESET,
  input  logic          BR_OUT,
  output logic          RESP_VALID,
  input  logic          RESP_READY,
  output logic          RESP,
  output logic [CW-1:0] RESP_ONES,
  output logic          BUSY
);

  localparam int TMAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] RST_LOAD    = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    LAST_EVAL   = 8'(NUM_EVALS - 1);
  localparam logic [CW-1:0] HALF        = CW'(NUM_EVALS / 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   br_c_q, br_c_d;
  logic          br_reset_q, br_reset_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    eval_q, eval_d;
  logic [CW-1:0] ones_q, ones_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_q, resp_d;
  logic [CW-1:0] resp_ones_q, resp_ones_d;
  logic          meta_q, sync_q;
  logic [CW-1:0] ones_inc;

  // Two-flop synchroniser; the ring output is only ever used through sync_q.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= BR_OUT;
      sync_q <= meta_q;
    end
  end

  // Next-state and registered-output computation for the evaluation sequence.
  always_comb begin
    state_d      = state_q;
    br_c_d       = br_c_q;
    br_reset_d   = br_reset_q;
    timer_d      = timer_q;
    eval_d       = eval_q;
    ones_d       = ones_q;
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    resp_ones_d  = resp_ones_q;
    ones_inc     = ones_q + CW'(sync_q);

    case (state_q)
      IDLE: begin
        if (CHAL_VALID) begin
          br_c_d     = CHAL;
          ones_d     = '0;
          eval_d     = '0;
          timer_d    = RST_LOAD;
          br_reset_d = 1'b1;
          state_d    = RST;
        end
      end
      RST: begin
        if (timer_q == '0) begin
          br_reset_d = 1'b0;
          timer_d    = SETTLE_LOAD;
          state_d    = SETTLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      SETTLE: begin
        if (timer_q == '0) begin
          state_d = SAMPLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      SAMPLE: begin
        ones_d = ones_inc;
        eval_d = eval_q + 8'd1;
        if (eval_q == LAST_EVAL) begin
          resp_valid_d = 1'b1;
          resp_d       = (ones_inc > HALF);
          resp_ones_d  = ones_inc;
          state_d      = DONE;
        end else begin
          br_reset_d = 1'b1;
          timer_d    = RST_LOAD;
          state_d    = RST;
        end
      end
      DONE: begin
        if (RESP_READY) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        br_reset_d   = 1'b0;
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partial evaluation.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      br_c_q       <= '0;
      br_reset_q   <= 1'b0;
      timer_q      <= '0;
      eval_q       <= '0;
      ones_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= 1'b0;
      resp_ones_q  <= '0;
    end else begin
      state_q      <= state_d;
      br_c_q       <= br_c_d;
      br_reset_q   <= br_reset_d;
      timer_q      <= timer_d;
      eval_q       <= eval_d;
      ones_q       <= ones_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      resp_ones_q  <= resp_ones_d;
    end
  end

  assign CHAL_READY = (state_q == IDLE);
  assign BUSY       = (state_q != IDLE);
  assign BR_C       = br_c_q;
  assign BR_RESET   = br_reset_q;
  assign RESP_VALID = resp_valid_q;
  assign RESP       = resp_q;
  assign RESP_ONES  = resp_ones_q;

endmodule

// File: tb/tb_br_puf_ctrl.sv
// Directed bench for br_puf_ctrl with a small behavioural ring model.
module tb_br_puf_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        CHAL_VALID;
  logic        CHAL_READY;
  logic [63:0] CHAL;
  logic [63:0] BR_C;
  logic        BR_RESET;
  logic        BR_OUT;
  logic        RESP_VALID;
  logic        RESP_READY;
  logic        RESP;
  logic [2:0]  RESP_ONES;
  logic        BUSY;

  int   vectors = 0;
  int   errors  = 0;
  int   mode    = 0;   // 0: ring output 0, 1: ring output 1, 2: toggles per reset pulse
  int   rises   = 0;
  int   base    = 0;
  logic glitch  = 1'b0;

  always #5 CLK = ~CLK;

  always @(posedge BR_RESET) rises <= rises + 1;

  assign BR_OUT = glitch | (mode == 1) | ((mode == 2) && (((rises - base) % 2) == 1));

  br_puf_ctrl dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .CHAL_VALID (CHAL_VALID),
    .CHAL_READY (CHAL_READY),
    .CHAL       (CHAL),
    .BR_C       (BR_C),
    .BR_RESET   (BR_RESET),
    .BR_OUT     (BR_OUT),
    .RESP_VALID (RESP_VALID),
    .RESP_READY (RESP_READY),
    .RESP       (RESP),
    .RESP_ONES  (RESP_ONES),
    .BUSY       (BUSY)
  );

  // One full challenge; cycle n counts from 1 = first cycle after the accepting edge.
  task automatic run_eval(input logic [63:0] chal, input logic exp_resp, input logic [2:0] exp_ones,
                          input int bp, input bit busy_chal, input int glitch_at, input string name);
    int   n;
    logic exp_rst;
    @(negedge CLK);
    vectors++;
    if (CHAL_READY !== 1'b1) begin
      errors++;
      $display("FAIL %s chal_ready_idle: got %b want 1", name, CHAL_READY);
    end
    CHAL       = chal;
    CHAL_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    n = 1;
    if (busy_chal) CHAL = ~chal;
    else CHAL_VALID = 1'b0;
    while (n < 106) begin
      exp_rst = (((n - 1) % 21) < 4);
      vectors++;
      if (BR_RESET !== exp_rst) begin
        errors++;
        $display("FAIL %s br_reset cyc %0d: got %b want %b", name, n, BR_RESET, exp_rst);
      end
      vectors++;
      if (BR_C !== chal) begin
        errors++;
        $display("FAIL %s br_c cyc %0d: got %h want %h", name, n, BR_C, chal);
      end
      vectors++;
      if (RESP_VALID !== 1'b0 || BUSY !== 1'b1 || CHAL_READY !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_flags cyc %0d: got v%b b%b r%b want v0 b1 r0", name, n,
                 RESP_VALID, BUSY, CHAL_READY);
      end
      if (n == glitch_at) begin
        #2 glitch = 1'b1;
        #1 glitch = 1'b0;
      end
      @(negedge CLK);
      n++;
    end
    CHAL_VALID = 1'b0;
    vectors++;
    if (RESP_VALID !== 1'b1 || RESP !== exp_resp || RESP_ONES !== exp_ones) begin
      errors++;
      $display("FAIL %s response cyc %0d: got v%b r%b ones%0d want v1 r%b ones%0d", name, n,
               RESP_VALID, RESP, RESP_ONES, exp_resp, exp_ones);
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge CLK);
      vectors++;
      if (RESP_VALID !== 1'b1 || RESP !== exp_resp || RESP_ONES !== exp_ones || CHAL_READY !== 1'b0) begin
        errors++;
        $display("FAIL %s backpressure hold %0d: got v%b r%b ones%0d rdy%b want v1 r%b ones%0d rdy0",
                 name, i, RESP_VALID, RESP, RESP_ONES, CHAL_READY, exp_resp, exp_ones);
      end
    end
    RESP_READY = 1'b1;
    @(negedge CLK);
    RESP_READY = 1'b0;
    vectors++;
    if (RESP_VALID !== 1'b0 || CHAL_READY !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s consume: got v%b rdy%b busy%b want v0 rdy1 busy0", name,
               RESP_VALID, CHAL_READY, BUSY);
    end
    vectors++;
    if (RESP !== exp_resp || RESP_ONES !== exp_ones || BR_C !== chal) begin
      errors++;
      $display("FAIL %s hold_after_consume: got r%b ones%0d c%h want r%b ones%0d c%h", name,
               RESP, RESP_ONES, BR_C, exp_resp, exp_ones, chal);
    end
  endtask

  task automatic test_reset();
    RESET_N    = 1'b0;
    CHAL_VALID = 1'b0;
    CHAL       = '0;
    RESP_READY = 1'b0;
    repeat (2) @(negedge CLK);
    vectors++;
    if (BR_C !== 64'h0 || BR_RESET !== 1'b0 || RESP_VALID !== 1'b0 || RESP !== 1'b0 ||
        RESP_ONES !== 3'd0 || CHAL_READY !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got c%h rst%b v%b r%b ones%0d rdy%b busy%b want all 0, rdy1",
               BR_C, BR_RESET, RESP_VALID, RESP, RESP_ONES, CHAL_READY, BUSY);
    end
    RESET_N = 1'b1;
    @(negedge CLK);
    vectors++;
    if (CHAL_READY !== 1'b1 || BUSY !== 1'b0 || BR_RESET !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy%b busy%b rst%b want rdy1 busy0 rst0",
               CHAL_READY, BUSY, BR_RESET);
    end
  endtask

  task automatic test_tied_one();
    mode = 1;
    run_eval(64'hDEADBEEF_01234567, 1'b1, 3'd5, 0, 1'b0, 0, "tied_one");
  endtask

  task automatic test_toggle();
    mode       = 2;
    base       = rises;
    RESP_READY = 1'b1;   // held high all run: must be ignored outside DONE
    run_eval(64'h0F0F_1234_5678_9ABC, 1'b1, 3'd3, 0, 1'b0, 0, "toggle");
  endtask

  task automatic test_tied_zero_busy();
    mode = 0;
    run_eval(64'hA5A5_5A5A_C3C3_3C3C, 1'b0, 3'd0, 0, 1'b1, 0, "tied_zero_busy");
  endtask

  task automatic test_backpressure();
    mode = 1;
    run_eval(64'h1111_2222_3333_4444, 1'b1, 3'd5, 20, 1'b0, 0, "backpressure");
  endtask

  task automatic test_reset_mid();
    mode = 1;
    @(negedge CLK);
    CHAL       = 64'hFEED_FACE_CAFE_BEEF;
    CHAL_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    CHAL_VALID = 1'b0;
    repeat (49) @(negedge CLK);   // cycle 50: inside the third settle window
    vectors++;
    if (BR_C !== 64'hFEED_FACE_CAFE_BEEF || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: got c%h busy%b want feedfacecafebeef busy1", BR_C, BUSY);
    end
    #2 RESET_N = 1'b0;
    #1;
    vectors++;
    if (BR_RESET !== 1'b0 || BR_C !== 64'h0 || RESP_VALID !== 1'b0 || BUSY !== 1'b0 ||
        CHAL_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_async: got rst%b c%h v%b busy%b rdy%b want 0 0 0 0 1",
               BR_RESET, BR_C, RESP_VALID, BUSY, CHAL_READY);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    run_eval(64'h0123_4567_89AB_CDEF, 1'b1, 3'd5, 0, 1'b0, 0, "after_reset_mid");
  endtask

  task automatic test_glitch();
    mode = 0;
    run_eval(64'h5555_AAAA_5555_AAAA, 1'b0, 3'd0, 0, 1'b0, 30, "glitch");
  endtask

  initial begin
    test_reset();
    test_tied_one();
    test_toggle();
    test_tied_zero_busy();
    test_backpressure();
    test_reset_mid();
    test_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
